// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, N data bits, optional
// parity bit, stop bit, with a valid/ready word handshake and registered outputs.
module piso_frame_tx #(
    parameter int N          = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic [N-1:0] data_in,
    input  logic         load_in,
    output logic         ready_out,
    output logic         q_out,
    output logic         busy_out,
    output logic         done_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int              CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic            ODD_BIT  = (PARITY_ODD != 0);

    state_t           state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             parity_q, parity_d;
    logic             q_q, q_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             out_bit;
    logic [N-1:0]     shift_adv;

    assign accept = load_in & ready_q;

    // The bit leaving the shift register and the register after it has left.
    always_comb begin
        if (MSB_FIRST != 0) begin
            out_bit   = shift_q[N-1];
            shift_adv = {shift_q[N-2:0], 1'b0};
        end else begin
            out_bit   = shift_q[0];
            shift_adv = {1'b0, shift_q[N-1:1]};
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;

        unique case (state_q)
            S_IDLE, S_STOP: begin
                if (accept) begin
                    state_d  = S_START;
                    shift_d  = data_in;
                    parity_d = (^data_in) ^ ODD_BIT;
                    cnt_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
                shift_d = shift_adv;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = shift_adv;
                end
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        unique case (state_d)
            S_START:  q_d = 1'b0;
            S_DATA:   q_d = out_bit;
            S_PARITY: q_d = parity_q;
            default:  q_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_STOP);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            q_q      <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            q_q      <= q_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign q_out     = q_q;
    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: four parameter variants driven in parallel, checked
// every cycle against a frame-position model plus hand-computed literal frames.
module tb_piso_frame_tx;

    // Variant k: 0 = MSB/even, 1 = MSB/odd, 2 = LSB/even, 3 = LSB/no parity.
    localparam logic [3:0] MSB_V = 4'b0011;
    localparam logic [3:0] PE_V  = 4'b0111;
    localparam logic [3:0] ODD_V = 4'b0010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in = 8'h00;
    logic       load_in = 1'b0;
    logic [3:0] q_o, rdy_o, busy_o, done_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piso_frame_tx #(.N(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_msb (
        .clk(clk), .reset_al_in(rst_n), .data_in(data_in), .load_in(load_in),
        .ready_out(rdy_o[0]), .q_out(q_o[0]), .busy_out(busy_o[0]), .done_out(done_o[0]));
    piso_frame_tx #(.N(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset_al_in(rst_n), .data_in(data_in), .load_in(load_in),
        .ready_out(rdy_o[1]), .q_out(q_o[1]), .busy_out(busy_o[1]), .done_out(done_o[1]));
    piso_frame_tx #(.N(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) dut_lsb (
        .clk(clk), .reset_al_in(rst_n), .data_in(data_in), .load_in(load_in),
        .ready_out(rdy_o[2]), .q_out(q_o[2]), .busy_out(busy_o[2]), .done_out(done_o[2]));
    piso_frame_tx #(.N(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
        .clk(clk), .reset_al_in(rst_n), .data_in(data_in), .load_in(load_in),
        .ready_out(rdy_o[3]), .q_out(q_o[3]), .busy_out(busy_o[3]), .done_out(done_o[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each variant is either idle (pos = -1) or at slot pos of a prebuilt frame.
    int         pos   [4];
    logic [10:0] fbits [4];
    logic       mdone [4];

    function automatic int flen(input int k);
        return 10 + int'(PE_V[k]);
    endfunction

    function automatic logic [10:0] build(input int k, input logic [7:0] d);
        logic [10:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int j = 0; j < 8; j++) b[1+j] = MSB_V[k] ? d[7-j] : d[j];
        if (PE_V[k]) b[9] = (^d) ^ ODD_V[k];
        return b;
    endfunction

    function automatic logic m_ready(input int k);
        return (pos[k] < 0) || (pos[k] == flen(k) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                pos[k]   <= -1;
                mdone[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                mdone[k] <= (pos[k] == flen(k) - 1);
                if (load_in && m_ready(k)) begin
                    pos[k]   <= 0;
                    fbits[k] <= build(k, data_in);
                end else if (pos[k] == flen(k) - 1) begin
                    pos[k] <= -1;
                end else if (pos[k] >= 0) begin
                    pos[k] <= pos[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check($sformatf("q_out[%0d]", k), 32'(q_o[k]),
                  32'((pos[k] < 0) ? 1'b1 : fbits[k][pos[k]]));
            check($sformatf("ready_out[%0d]", k), 32'(rdy_o[k]), 32'(m_ready(k)));
            check($sformatf("busy_out[%0d]", k), 32'(busy_o[k]), 32'(pos[k] >= 0));
            check($sformatf("done_out[%0d]", k), 32'(done_o[k]), 32'(mdone[k]));
        end
    end

    // Per-frame recordings; the first sampled cycle lands in the highest used bit.
    logic [31:0] rec_q [4];
    logic [31:0] rec_done [4];
    int          busy_cnt [4];
    int          done_cnt [4];
    int          rdy_lo_cnt [4];

    // Accept word d, then sample nc cycles (cycle 1 = start bit). In cycles lo..hi
    // load_in is raised again carrying word junk.
    task automatic frame(input logic [7:0] d, input int nc, input int lo, input int hi,
                         input logic [7:0] junk);
        @(posedge clk); #1;
        load_in = 1'b1;
        data_in = d;
        @(posedge clk); #1;
        load_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rec_q[k] = '0; rec_done[k] = '0;
            busy_cnt[k] = 0; done_cnt[k] = 0; rdy_lo_cnt[k] = 0;
        end
        for (int i = 0; i < nc; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                rec_q[k]    = {rec_q[k][30:0], q_o[k]};
                rec_done[k] = {rec_done[k][30:0], done_o[k]};
                busy_cnt[k]   += int'(busy_o[k]);
                done_cnt[k]   += int'(done_o[k]);
                rdy_lo_cnt[k] += int'(!rdy_o[k]);
            end
            if (i + 1 >= lo && i + 1 <= hi) begin
                load_in = 1'b1;
                data_in = junk;
            end else begin
                load_in = 1'b0;
            end
        end
        load_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset state, checked while reset is still held.
        #20;
        check("reset q_out", 32'(q_o[0]), 32'd1);
        check("reset ready_out", 32'(rdy_o[0]), 32'd1);
        check("reset busy_out", 32'(busy_o[0]), 32'd0);
        check("reset done_out", 32'(done_o[0]), 32'd0);
        #32 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // 0xA5, even and odd parity, MSB and LSB first.
        frame(8'hA5, 13, 0, -1, 8'h00);
        check("A5 msb even stream", rec_q[0][12:0], 32'(13'b0101001010111));
        check("A5 msb odd stream",  rec_q[1][12:0], 32'(13'b0101001011111));
        check("A5 lsb even stream", rec_q[2][12:0], 32'(13'b0101001010111));
        check("A5 lsb nopar stream", rec_q[3][12:0], 32'(13'b0101001011111));
        check("A5 busy cycles", 32'(busy_cnt[0]), 32'd11);
        check("A5 nopar busy cycles", 32'(busy_cnt[3]), 32'd10);
        check("A5 done pulses", 32'(done_cnt[0]), 32'd1);
        repeat (3) @(posedge clk);

        // 0x01 LSB first, with and without a parity slot.
        frame(8'h01, 13, 0, -1, 8'h00);
        check("01 lsb even stream", rec_q[2][12:0], 32'(13'b0100000001111));
        check("01 lsb nopar stream", rec_q[3][12:0], 32'(13'b0100000001111));
        check("01 msb even stream", rec_q[0][12:0], 32'(13'b0000000011111));
        repeat (3) @(posedge clk);

        // Back-to-back: load held high, 0xFF then 0x00.
        frame(8'hFF, 24, 1, 11, 8'h00);
        check("b2b stream", rec_q[0][23:0], 32'(24'b011111111010000000000111));
        check("b2b done pattern", rec_done[0][23:0], 32'h001002);
        check("b2b busy cycles", 32'(busy_cnt[0]), 32'd22);
        repeat (3) @(posedge clk);

        // Load attempt during DATA is ignored.
        frame(8'h3C, 13, 3, 6, 8'hC3);
        check("reject stream", rec_q[0][12:0], 32'(13'b0001111000111));
        check("reject ready low cycles", 32'(rdy_lo_cnt[0]), 32'd10);
        check("reject done pulses", 32'(done_cnt[0]), 32'd1);
        repeat (3) @(posedge clk);

        // Reset while data bit 4 of 0xA5 is on the line.
        frame(8'hA5, 6, 0, -1, 8'h00);
        check("pre-abort stream", rec_q[0][5:0], 32'(6'b010100));
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort q_out[%0d]", k), 32'(q_o[k]), 32'd1);
            check($sformatf("abort busy_out[%0d]", k), 32'(busy_o[k]), 32'd0);
            check($sformatf("abort done_out[%0d]", k), 32'(done_o[k]), 32'd0);
        end
        #20 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        frame(8'h5A, 13, 0, -1, 8'h00);
        check("5A stream", rec_q[0][12:0], 32'(13'b0010110100111));
        check("5A done pulses", 32'(done_cnt[0]), 32'd1);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
